// File: rtl/ps2_key_fifo_if.sv
// Keyboard-port bundle between the PS/2 receiver, the scancode FIFO
// and the processor's memory-mapped polling port.
interface ps2_key_fifo_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
);
   logic              ps2_key_pressed;
   logic [DATA_W-1:0] ps2_key_data;
   logic              rd_en;
   logic              clr_overflow;
   logic [DATA_W-1:0] rd_data;
   logic              empty;
   logic              full;
   logic [ADDR_W:0]   count;
   logic              overflow;

   modport master (
      output ps2_key_pressed,
      output ps2_key_data,
      output rd_en,
      output clr_overflow,
      input  rd_data,
      input  empty,
      input  full,
      input  count,
      input  overflow
   );

   modport slave (
      input  ps2_key_pressed,
      input  ps2_key_data,
      input  rd_en,
      input  clr_overflow,
      output rd_data,
      output empty,
      output full,
      output count,
      output overflow
   );
endinterface

// File: rtl/ps2_key_fifo.sv
// Scancode FIFO with a make-code filter: break sequences are stripped,
// extended (E0) keys are tagged by setting bit 7 of the pushed byte.
module ps2_key_fifo #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
) (
   input  logic          clock,
   input  logic          reset,
   ps2_key_fifo_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BREAK,
      S_EXT,
      S_EXT_BREAK
   } state_t;

   localparam logic [DATA_W-1:0] BRK_CODE = DATA_W'(8'hF0);
   localparam logic [DATA_W-1:0] EXT_CODE = DATA_W'(8'hE0);
   localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W+1)'(DEPTH);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                ovf_q, ovf_d;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                push_req;
   logic [DATA_W-1:0]   push_data;
   logic                is_brk;
   logic                is_ext;
   logic                pop;
   logic                accept;
   logic                drop;

   assign is_brk = (bus.ps2_key_data == BRK_CODE);
   assign is_ext = (bus.ps2_key_data == EXT_CODE);

   // The filter never stalls: a push that finds the FIFO full is simply lost.
   always_comb begin
      state_d   = state_q;
      push_req  = 1'b0;
      push_data = bus.ps2_key_data;
      if (bus.ps2_key_pressed) begin
         unique case (state_q)
            S_IDLE: begin
               unique case (1'b1)
                  is_brk:  state_d = S_BREAK;
                  is_ext:  state_d = S_EXT;
                  default: push_req = 1'b1;
               endcase
            end
            S_EXT: begin
               unique case (1'b1)
                  is_brk:  state_d = S_EXT_BREAK;
                  is_ext:  state_d = S_EXT;
                  default: begin
                     push_req  = 1'b1;
                     push_data = {1'b1, bus.ps2_key_data[DATA_W-2:0]};
                     state_d   = S_IDLE;
                  end
               endcase
            end
            S_BREAK:     state_d = S_IDLE;
            S_EXT_BREAK: state_d = S_IDLE;
            default:     state_d = S_IDLE;
         endcase
      end
   end

   assign pop    = bus.rd_en && (count_q != '0);
   assign accept = push_req && ((count_q != CNT_MAX) || pop);
   assign drop   = push_req && (count_q == CNT_MAX) && !pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (accept) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      unique case ({accept, pop})
         2'b10:   count_d = count_q + (ADDR_W+1)'(1);
         2'b01:   count_d = count_q - (ADDR_W+1)'(1);
         default: count_d = count_q;
      endcase
      // Set has priority over a coincident clear.
      if (bus.clr_overflow) ovf_d = 1'b0;
      if (drop)             ovf_d = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clock) begin
      if (accept) mem[wr_ptr_q] <= push_data;
   end

   assign bus.rd_data  = (count_q == '0) ? '0 : mem[rd_ptr_q];
   assign bus.empty    = (count_q == '0);
   assign bus.full     = (count_q == CNT_MAX);
   assign bus.count    = count_q;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Scoreboard bench for ps2_key_fifo: expected make codes are queued as
// stimulus is driven and checked as the processor side pops them.
module tb_ps2_key_fifo;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [7:0] exp_q [$];

   ps2_key_fifo_if #(.ADDR_W(3), .DATA_W(8)) bus ();

   ps2_key_fifo #(.DEPTH(8), .ADDR_W(3), .DATA_W(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic step(input logic kp, input logic [7:0] kd,
                       input logic rd, input logic clr);
      @(negedge clock);
      bus.ps2_key_pressed = kp;
      bus.ps2_key_data    = kd;
      bus.rd_en           = rd;
      bus.clr_overflow    = clr;
      @(posedge clock);
      #1;
      bus.ps2_key_pressed = 1'b0;
      bus.rd_en           = 1'b0;
      bus.clr_overflow    = 1'b0;
   endtask

   // Strobe a byte; queue the expected entry if the byte should be stored.
   task automatic strobe(input logic [7:0] kd, input logic exp_push,
                         input logic [7:0] exp_val);
      if (exp_push && exp_q.size() < 8) exp_q.push_back(exp_val);
      step(1'b1, kd, 1'b0, 1'b0);
   endtask

   task automatic sb_drain(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s underflow: scoreboard empty, need entry %0d",
                     name, i);
         end else begin
            if (bus.rd_data !== exp_q[0]) begin
               n_err++;
               $display("FAIL %s rd_data[%0d]: got %h want %h",
                        name, i, bus.rd_data, exp_q[0]);
            end
            n_cmp++;
            if (bus.count !== 4'(exp_q.size())) begin
               n_err++;
               $display("FAIL %s count[%0d]: got %0d want %0d",
                        name, i, bus.count, exp_q.size());
            end
            void'(exp_q.pop_front());
         end
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      n_cmp++;
      if (bus.empty !== 1'b1 || bus.rd_data !== 8'h00) begin
         n_err++;
         $display("FAIL %s drained: empty=%b rd_data=%h want 1/00",
                  name, bus.empty, bus.rd_data);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      #1;
      n_cmp++;
      if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
         n_err++;
         $display("FAIL async_reset: count=%0d empty=%b want 0/1",
                  bus.count, bus.empty);
      end
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clock);
      #1;
      n_cmp++;
      if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
          bus.overflow !== 1'b0 || bus.rd_data !== 8'h00) begin
         n_err++;
         $display("FAIL reset: cnt=%0d e=%b f=%b ovf=%b rd=%h want 0/1/0/0/00",
                  bus.count, bus.empty, bus.full, bus.overflow, bus.rd_data);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_single();
      strobe(8'h1C, 1'b1, 8'h1C);
      n_cmp++;
      if (bus.empty !== 1'b0 || bus.count !== 4'd1 || bus.rd_data !== 8'h1C) begin
         n_err++;
         $display("FAIL single: e=%b cnt=%0d rd=%h want 0/1/1c",
                  bus.empty, bus.count, bus.rd_data);
      end
      sb_drain("single", 1);
   endtask

   task automatic test_break();
      strobe(8'h1C, 1'b1, 8'h1C);
      strobe(8'hF0, 1'b0, 8'h00);
      strobe(8'h1C, 1'b0, 8'h00);
      n_cmp++;
      if (bus.count !== 4'd1) begin
         n_err++;
         $display("FAIL break_count: got %0d want 1", bus.count);
      end
      // FSM must be back in IDLE: the next plain byte is stored.
      strobe(8'h32, 1'b1, 8'h32);
      sb_drain("break", 2);
   endtask

   task automatic test_extended();
      strobe(8'hE0, 1'b0, 8'h00);
      strobe(8'h75, 1'b1, 8'hF5);
      strobe(8'hE0, 1'b0, 8'h00);
      strobe(8'hF0, 1'b0, 8'h00);
      strobe(8'h75, 1'b0, 8'h00);
      n_cmp++;
      if (bus.count !== 4'd1 || bus.rd_data !== 8'hF5) begin
         n_err++;
         $display("FAIL ext: cnt=%0d rd=%h want 1/f5", bus.count, bus.rd_data);
      end
      strobe(8'hE0, 1'b0, 8'h00);
      strobe(8'hE0, 1'b0, 8'h00);
      strobe(8'h74, 1'b1, 8'hF4);
      sb_drain("ext", 2);
   endtask

   task automatic test_empty_pop();
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n_cmp++;
      if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
         n_err++;
         $display("FAIL empty_pop: cnt=%0d e=%b want 0/1", bus.count, bus.empty);
      end
      exp_q.push_back(8'h29);
      step(1'b1, 8'h29, 1'b1, 1'b0);
      n_cmp++;
      if (bus.count !== 4'd1 || bus.rd_data !== 8'h29) begin
         n_err++;
         $display("FAIL empty_push_pop: cnt=%0d rd=%h want 1/29",
                  bus.count, bus.rd_data);
      end
      sb_drain("empty_pop", 1);
   endtask

   task automatic test_overflow();
      logic [7:0] codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
                                8'h35, 8'h3C, 8'h43, 8'h44};
      for (int i = 0; i < 9; i++) strobe(codes[i], 1'b1, codes[i]);
      n_cmp++;
      if (bus.full !== 1'b1 || bus.count !== 4'd8 || bus.overflow !== 1'b1) begin
         n_err++;
         $display("FAIL overflow: f=%b cnt=%0d ovf=%b want 1/8/1",
                  bus.full, bus.count, bus.overflow);
      end
      sb_drain("overflow", 8);
      n_cmp++;
      if (bus.overflow !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_sticky: got %b want 1", bus.overflow);
      end
      step(1'b0, 8'h00, 1'b0, 1'b1);
      n_cmp++;
      if (bus.overflow !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_clear: got %b want 0", bus.overflow);
      end
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 8; i++) strobe(8'h16 + 8'(i), 1'b1, 8'h16 + 8'(i));
      n_cmp++;
      if (bus.rd_data !== exp_q[0]) begin
         n_err++;
         $display("FAIL full_pp head: got %h want %h", bus.rd_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      exp_q.push_back(8'h4D);
      step(1'b1, 8'h4D, 1'b1, 1'b0);
      n_cmp++;
      if (bus.count !== 4'd8 || bus.overflow !== 1'b0 || bus.full !== 1'b1) begin
         n_err++;
         $display("FAIL full_pp: cnt=%0d ovf=%b f=%b want 8/0/1",
                  bus.count, bus.overflow, bus.full);
      end
      // Full with no pop, drop and clear together: set must win.
      step(1'b1, 8'h5A, 1'b0, 1'b1);
      n_cmp++;
      if (bus.overflow !== 1'b1 || bus.count !== 4'd8) begin
         n_err++;
         $display("FAIL set_vs_clr: ovf=%b cnt=%0d want 1/8",
                  bus.overflow, bus.count);
      end
      sb_drain("full_pp", 8);
      step(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid_seq();
      for (int i = 0; i < 9; i++) strobe(8'h1A, 1'b1, 8'h1A);
      strobe(8'hF0, 1'b0, 8'h00);
      do_reset();
      n_cmp++;
      if (bus.count !== 4'd0 || bus.overflow !== 1'b0 || bus.full !== 1'b0 ||
          bus.rd_data !== 8'h00) begin
         n_err++;
         $display("FAIL post_reset: cnt=%0d ovf=%b f=%b rd=%h want 0/0/0/00",
                  bus.count, bus.overflow, bus.full, bus.rd_data);
      end
      strobe(8'h1C, 1'b1, 8'h1C);
      n_cmp++;
      if (bus.count !== 4'd1 || bus.overflow !== 1'b0 || bus.rd_data !== 8'h1C) begin
         n_err++;
         $display("FAIL mid_seq: cnt=%0d ovf=%b rd=%h want 1/0/1c",
                  bus.count, bus.overflow, bus.rd_data);
      end
      sb_drain("mid_seq", 1);
   endtask

   task automatic test_wrap();
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 5; i++) begin
            strobe(8'h20 + 8'(r * 5 + i), 1'b1, 8'h20 + 8'(r * 5 + i));
         end
         sb_drain("wrap", 5);
      end
   endtask

   initial begin
      bus.ps2_key_pressed = 1'b0;
      bus.ps2_key_data    = 8'h00;
      bus.rd_en           = 1'b0;
      bus.clr_overflow    = 1'b0;
      test_reset();
      test_single();
      test_break();
      test_extended();
      test_empty_pop();
      test_overflow();
      test_full_push_pop();
      test_reset_mid_seq();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ps2_key_fifo.md
Name: ps2_key_fifo

Overview:
- Buffers PS/2 keyboard scancodes between the PS/2 receive controller and the pipelined processor's memory-mapped keyboard port.
- A filter FSM strips break (key-release) sequences and tags extended keys, so the processor sees only make codes.
- The processor polls `empty` and pops with a one-cycle read strobe. The FIFO decouples keystroke timing from pipeline stalls.

Parameters:
- DEPTH, 8, number of FIFO entries (power of two).
- ADDR_W, 3, log2(DEPTH); pointer width.
- DATA_W, 8, scancode width.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- ps2_key_pressed  input  1  one-cycle strobe: new byte valid on ps2_key_data.
- ps2_key_data  input  DATA_W  raw scancode byte from the PS/2 controller.
- rd_en  input  1  processor pop strobe; one entry removed per asserted cycle.
- rd_data  output  DATA_W  head entry (first-word-fall-through); 0 when empty.
- empty  output  1  high when count == 0.
- full  output  1  high when count == DEPTH.
- count  output  ADDR_W+1  number of valid entries, 0..DEPTH.
- overflow  output  1  sticky: a filtered code was dropped because the FIFO was full.
- clr_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async, active-high):
  - wr_ptr = rd_ptr = 0, count = 0, overflow = 0, FSM = IDLE.
  - rd_data = 0, empty = 1, full = 0.
  - Storage array is not cleared.
  - Reset mid-sequence (e.g. after F0) abandons the sequence; the next byte is interpreted from IDLE.
- Filter FSM advances only on cycles with ps2_key_pressed = 1:
  - IDLE: byte F0 -> BREAK; E0 -> EXT; any other byte -> push byte, stay IDLE.
  - BREAK: any byte discarded -> IDLE.
  - EXT: F0 -> EXT_BREAK; E0 -> stay EXT, no push; other -> push {1'b1, byte[6:0]} -> IDLE.
  - EXT_BREAK: any byte discarded -> IDLE.
  - The FSM advances regardless of FIFO fullness; a dropped push does not stall the FSM.
- Push:
  - Writes mem[wr_ptr] at the clock edge; wr_ptr increments modulo DEPTH.
  - Latency: strobe in cycle N makes the entry visible on rd_data / empty / count after edge N+1.
- Pop:
  - rd_en = 1 with count > 0 increments rd_ptr modulo DEPTH at the edge.
  - rd_data shows the next entry combinationally afterwards.
  - rd_en while empty is ignored: no pointer change, no error flag.
- Simultaneous push and pop:
  - Non-empty, non-full: both occur, count unchanged.
  - Full: both occur. The pop frees the slot, the push is accepted, count stays DEPTH, overflow is not set.
  - Empty: the pop is ignored, the push is accepted, count becomes 1.
- Overflow:
  - A push with count == DEPTH and no pop in the same cycle drops the code and sets overflow = 1.
  - clr_overflow clears it on the next edge.
  - If set and clear coincide, set wins.
- Outputs:
  - count is a registered up/down counter; empty and full decode from it.
  - rd_data = (count == 0) ? 0 : mem[rd_ptr].
- Pointers: wrap from DEPTH-1 to 0 with no gap. After DEPTH pushes and DEPTH pops the pointers are back at 0.

Test Plan:
- Reset, then strobe byte 1C (A) -> after one edge: empty = 0, count = 1, rd_data = 1C. Pulse rd_en -> empty = 1, rd_data = 00.
- Strobe sequence 1C, F0, 1C -> exactly one entry 1C; FSM back in IDLE; count = 1.
- Strobe E0, 75 (up arrow), then E0, F0, 75 -> one entry F5, count = 1, nothing pushed for the release.
- Push 9 distinct make codes 15, 1D, 24, 2D, 2C, 35, 3C, 43, 44 with no pops -> full = 1, count = 8, overflow = 1, 44 dropped. Pop 8 -> rd_data yields 15..43 in order, then empty = 1. Pulse clr_overflow -> overflow = 0.
- FIFO full, strobe 4D with rd_en = 1 in the same cycle -> count stays 8, overflow stays 0, 4D is the last entry read out.
- Strobe F0, assert reset for one cycle, release, strobe 1C -> 1C is pushed (the break sequence is abandoned), count = 1, overflow = 0.
